// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave sa
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             bit_s, bit_c;

  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign sa.ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (sa.start) begin
          a_d     = sa.a;
          b_d     = sa.b;
          carry_d = sa.c_in;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = {bit_s, psum_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          sum_d   = psum_d;
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB step carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ bit_c;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sa.busy  = (state_q == StAdd);
  assign sa.done  = (state_q == StDone);
  assign sa.sum   = sum_q;
  assign sa.c_out = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2,
// compared against a plain-arithmetic model (ovf checked only with SERIAL_ADDER_OVF_EN).
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(2)) if2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .sa(if8.slave));
  serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .sa(if2.slave));

  logic [7:0] exp_sum8;
  logic       exp_cout8;
  logic       exp_ovf8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, c_out, sum[31:0]} for a w-bit addition.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] s;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, av & mask} + {1'b0, bv & mask} + {32'd0, cv};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  task automatic check_ovf8(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    check(tag, {63'd0, if8.ovf}, {63'd0, exp});
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input bit poke);
    logic [33:0] m;
    m = model(8, {24'd0, av}, {24'd0, bv}, cv);
    if8.start = 1'b1;
    if8.a     = av;
    if8.b     = bv;
    if8.c_in  = cv;
    tick();
    for (int i = 0; i < 8; i++) begin
      if8.a     = 8'($urandom);
      if8.b     = 8'($urandom);
      if8.c_in  = 1'($urandom);
      if8.start = poke && (i == 2);
      check("busy8", {63'd0, if8.busy}, 64'd1);
      check("done_early8", {63'd0, if8.done}, 64'd0);
      check("sum_hold8", {56'd0, if8.sum}, {56'd0, exp_sum8});
      tick();
    end
    if8.start = 1'b0;
    check("done8", {63'd0, if8.done}, 64'd1);
    check("busy_done8", {63'd0, if8.busy}, 64'd0);
    check("sum8", {56'd0, if8.sum}, {56'd0, m[7:0]});
    check("cout8", {63'd0, if8.c_out}, {63'd0, m[32]});
    check_ovf8("ovf8", m[33]);
    exp_sum8  = m[7:0];
    exp_cout8 = m[32];
    exp_ovf8  = m[33];
    tick();
    check("done_pulse8", {63'd0, if8.done}, 64'd0);
    check("busy_after8", {63'd0, if8.busy}, 64'd0);
    check("sum_keep8", {56'd0, if8.sum}, {56'd0, exp_sum8});
  endtask

  initial begin
    logic [33:0] m;
    logic [33:0] q[$];
    int          last_done;
    int          n_done;
    int          lat;
    logic [1:0]  a2, b2;
    logic        c2;

    rst = 1'b1;
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.c_in = 1'b1;
    if2.start = 1'b1; if2.a = 2'd3;  if2.b = 2'd3;  if2.c_in = 1'b1;
    tick();
    tick();
    // rst wins over start on the same edge
    check("rst_busy8", {63'd0, if8.busy}, 64'd0);
    check("rst_busy2", {63'd0, if2.busy}, 64'd0);
    if8.start = 1'b0;
    if2.start = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_done8", {63'd0, if8.done}, 64'd0);
    check("rst_sum8", {56'd0, if8.sum}, 64'd0);
    check("rst_cout8", {63'd0, if8.c_out}, 64'd0);
    check_ovf8("rst_ovf8", 1'b0);
    exp_sum8 = 8'd0; exp_cout8 = 1'b0; exp_ovf8 = 1'b0;

    // Directed vectors
    run_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("vec_5a3c", {56'd0, if8.sum}, 64'h96);
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    check("vec_ff01_cout", {63'd0, if8.c_out}, 64'd1);
    run_op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("vec_ffff1", {56'd0, if8.sum}, 64'hFF);
    run_op8(8'h12, 8'h34, 1'b1, 1'b1);

    // Reset at the 4th ADD edge abandons the operation
    if8.start = 1'b1; if8.a = 8'h77; if8.b = 8'h66; if8.c_in = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {63'd0, if8.busy}, 64'd0);
    check("mid_rst_done", {63'd0, if8.done}, 64'd0);
    check("mid_rst_sum", {56'd0, if8.sum}, 64'd0);
    check("mid_rst_cout", {63'd0, if8.c_out}, 64'd0);
    check_ovf8("mid_rst_ovf", 1'b0);
    exp_sum8 = 8'd0; exp_cout8 = 1'b0; exp_ovf8 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.done) n_done++;
    end
    check("mid_rst_no_done", 64'(n_done), 64'd0);
    run_op8(8'hC3, 8'h81, 1'b0, 1'b0);

    // start held high: accepts every WIDTH+2 edges
    if8.start = 1'b1;
    last_done = -1;
    n_done    = 0;
    for (int t = 0; t < 30; t++) begin
      if8.a    = 8'($urandom);
      if8.b    = 8'($urandom);
      if8.c_in = 1'($urandom);
      if (t % 10 == 0) q.push_back(model(8, {24'd0, if8.a}, {24'd0, if8.b}, if8.c_in));
      if (t == 29) if8.start = 1'b0;
      tick();
      if (if8.done) begin
        n_done++;
        if (last_done >= 0) check("hold_spacing", 64'(t - last_done), 64'd10);
        last_done = t;
        if (q.size() > 0) begin
          m = q.pop_front();
          check("hold_sum", {56'd0, if8.sum}, {56'd0, m[7:0]});
          check("hold_cout", {63'd0, if8.c_out}, {63'd0, m[32]});
          check_ovf8("hold_ovf", m[33]);
          exp_sum8 = m[7:0]; exp_cout8 = m[32]; exp_ovf8 = m[33];
        end
      end
    end
    if8.start = 1'b0;
    check("hold_count", 64'(n_done), 64'd3);
    tick();

    // Random WIDTH=8
    for (int n = 0; n < 1000; n++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Random WIDTH=2
    for (int n = 0; n < 1000; n++) begin
      a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom);
      m  = model(2, {30'd0, a2}, {30'd0, b2}, c2);
      if2.start = 1'b1; if2.a = a2; if2.b = b2; if2.c_in = c2;
      tick();
      if2.start = 1'b0;
      if2.a = 2'($urandom); if2.b = 2'($urandom);
      lat = 0;
      while (!if2.done && lat < 10) begin
        tick();
        lat++;
      end
      check("lat2", 64'(lat), 64'd2);
      check("sum2", {62'd0, if2.sum}, {62'd0, m[1:0]});
      check("cout2", {63'd0, if2.c_out}, {63'd0, m[32]});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf2", {63'd0, if2.ovf}, {63'd0, m[33]});
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to add; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 SHALL have port c_in  input  1  carry-in; captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high while bit-serial addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result of the last completed addition.
REQ-011 SHALL have port c_out  output  1  registered carry-out of the last completed addition.
REQ-012 SHALL have port ovf  output  1  signed overflow of the last completed addition; present only with SERIAL_ADDER_OVF_EN.

Function
REQ-013 SHALL sequence one full-adder bit cell (sum = a^b^c, carry = ab|ac|bc) over WIDTH cycles, LSB first, with a carry flip-flop between bits.
REQ-014 SHALL implement states IDLE, ADD and DONE; encoding is free.
REQ-015 In IDLE with start=1, SHALL load a, b and c_in into the operand shift registers and carry flip-flop, clear the bit counter and enter ADD; start=0 stays in IDLE.
REQ-016 In ADD, each edge SHALL process the current LSBs, shift both operands right, shift the sum bit into the MSB of the partial-sum register, update the carry and increment the counter.
REQ-017 SHALL leave ADD after exactly WIDTH processing edges and enter DONE; on that edge it SHALL copy the partial sum to sum and the final carry to c_out.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in ADD; done SHALL be 1 exactly in DONE; both are decoded from registered state only.
REQ-020 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH; busy SHALL be high in the cycles following edges k..k+WIDTH-1.
REQ-021 start SHALL be ignored in ADD and DONE; changes on a/b/c_in after acceptance SHALL NOT affect the result.
REQ-022 With start held high continuously, the block SHALL accept a new operation every WIDTH+2 edges.
REQ-023 sum, c_out (and ovf) SHALL hold their values between completions and change only on the edge entering DONE.
REQ-024 Results SHALL equal (a + b + c_in) mod 2^WIDTH, with c_out = bit WIDTH of the full sum.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE and set busy=0, done=0, sum=0, c_out=0, ovf=0, counter=0, carry=0.
REQ-026 Reset during ADD or DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-027 rst SHALL take priority over start on the same edge.

Configuration
REQ-028 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL provide ovf = carry into MSB XOR carry out of MSB, registered alongside sum.
REQ-029 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x3C, c_in=0, 1-cycle start -> sum=0x96, c_out=0, ovf=1, done 8 edges after start.
REQ-031 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, ovf=0.
REQ-032 start pulsed again, with a/b changed, during ADD -> ignored; first result unchanged; exactly one done pulse.
REQ-033 rst asserted at the 4th ADD edge -> next cycle IDLE, all outputs 0, no done; a new start then completes normally.
REQ-034 start held high for three operations -> done pulses spaced 10 edges apart (WIDTH=8); each result matches its captured operands.
REQ-035 Random 1000 operand triples, WIDTH=8 and WIDTH=2 -> sum/c_out/ovf match the arithmetic model on every done.
